// File: rtl/snake_step_scheduler.sv
// Snake game step scheduler: speed-dependent tick divider feeding vblank-aligned move/grow handshakes.
// state_dbg exposes the FSM encoding: 0 IDLE, 1 RUN, 2 WAIT_VB, 3 MOVE, 4 GROW, 5 OVER.
module snake_step_scheduler #(
    parameter int unsigned DIV_BASE   = 4000000,
    parameter int unsigned SPEED_STEP = 400000,
    parameter int unsigned DIV_MIN    = 1000000,
    parameter int          CW         = 22
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        pause,
    input  logic [2:0]  speed,
    input  logic        vblank,
    output logic        move_req,
    input  logic        move_ack,
    input  logic        collide,
    input  logic        ate,
    output logic        grow_req,
    input  logic        grow_ack,
    output logic        busy,
    output logic        game_over,
    output logic [15:0] step_count,
    output logic        tick_missed,
    output logic [2:0]  state_dbg
);

    // Handshakes: a request rises on entry to its state and is held until the
    // cycle its one-cycle ack is seen; it drops on the edge that accepts the ack.
    // Acks arriving outside the matching state are ignored.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RUN     = 3'd1,
        ST_WAIT_VB = 3'd2,
        ST_MOVE    = 3'd3,
        ST_GROW    = 3'd4,
        ST_OVER    = 3'd5
    } state_t;

    localparam int XW = CW + 4;
    localparam logic [XW-1:0] BASE_X = XW'(DIV_BASE);
    localparam logic [XW-1:0] MIN_X  = XW'(DIV_MIN);
    localparam logic [XW-1:0] STEP_X = XW'(SPEED_STEP);

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic [CW-1:0] period;
    logic [XW-1:0] reduce_x;
    logic [2:0]    speed_lat;
    logic          tick_pending;
    logic          active, count_en, tick, consume, restart, step_inc;

    // Period is evaluated wide so a large speed reduction clamps to the floor
    // instead of wrapping below zero.
    always_comb begin
        reduce_x = XW'(speed_lat) * STEP_X;
        if (reduce_x + MIN_X > BASE_X) period = CW'(DIV_MIN);
        else                           period = CW'(BASE_X - reduce_x);
    end

    always_comb begin
        active   = (state == ST_RUN) || (state == ST_WAIT_VB) ||
                   (state == ST_MOVE) || (state == ST_GROW);
        count_en = active && !pause;
        tick     = count_en && (cnt == period - CW'(1));
        consume  = (state == ST_WAIT_VB) && vblank;
        restart  = start && ((state == ST_IDLE) || (state == ST_OVER));
        step_inc = (state == ST_MOVE) && move_ack && !collide;
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:    if (start) state_next = ST_RUN;
            ST_RUN:     if (tick_pending && !pause) state_next = ST_WAIT_VB;
            ST_WAIT_VB: if (vblank) state_next = ST_MOVE;
            ST_MOVE: begin
                if (move_ack) begin
                    if (collide)  state_next = ST_OVER;
                    else if (ate) state_next = ST_GROW;
                    else          state_next = ST_RUN;
                end
            end
            ST_GROW:    if (grow_ack) state_next = ST_RUN;
            ST_OVER:    if (start) state_next = ST_RUN;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= state_next;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt          <= '0;
            speed_lat    <= '0;
            tick_pending <= 1'b0;
            tick_missed  <= 1'b0;
            step_count   <= '0;
            move_req     <= 1'b0;
            grow_req     <= 1'b0;
            busy         <= 1'b0;
            game_over    <= 1'b0;
        end else begin
            // Speed is only sampled at a period boundary so a running period keeps its length.
            if (cnt == '0) speed_lat <= speed;
            if (restart) begin
                cnt          <= '0;
                tick_pending <= 1'b0;
                tick_missed  <= 1'b0;
                step_count   <= '0;
            end else begin
                if (tick)          cnt <= '0;
                else if (count_en) cnt <= cnt + CW'(1);
                // A tick landing on the edge that consumes the previous one is not an overrun.
                if (tick) begin
                    tick_pending <= 1'b1;
                    if (tick_pending && !consume) tick_missed <= 1'b1;
                end else if (consume) begin
                    tick_pending <= 1'b0;
                end
                if (step_inc) step_count <= step_count + 16'd1;
            end
            move_req  <= (state_next == ST_MOVE);
            grow_req  <= (state_next == ST_GROW);
            busy      <= (state_next == ST_WAIT_VB) || (state_next == ST_MOVE) ||
                         (state_next == ST_GROW);
            game_over <= (state_next == ST_OVER);
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_snake_step_scheduler.sv
// Self-checking bench for snake_step_scheduler with a small divider configuration.
module tb_snake_step_scheduler;
    localparam int DIV_BASE   = 10;
    localparam int SPEED_STEP = 2;
    localparam int DIV_MIN    = 4;
    localparam int CW         = 5;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RUN  = 3'd1;
    localparam logic [2:0] S_WAIT = 3'd2;
    localparam logic [2:0] S_MOVE = 3'd3;
    localparam logic [2:0] S_GROW = 3'd4;
    localparam logic [2:0] S_OVER = 3'd5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        pause = 1'b0;
    logic [2:0]  speed = 3'd0;
    logic        vblank = 1'b0;
    logic        move_ack = 1'b0;
    logic        collide = 1'b0;
    logic        ate = 1'b0;
    logic        grow_ack = 1'b0;
    logic        move_req, grow_req, busy, game_over, tick_missed;
    logic [15:0] step_count;
    logic [2:0]  state_dbg;

    int          checks = 0;
    int          errors = 0;
    int unsigned cyc_now = 0;
    logic [15:0] exp_q[$];
    logic [15:0] sb_steps = 16'd0;

    snake_step_scheduler #(
        .DIV_BASE(DIV_BASE), .SPEED_STEP(SPEED_STEP), .DIV_MIN(DIV_MIN), .CW(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .pause(pause), .speed(speed),
        .vblank(vblank), .move_req(move_req), .move_ack(move_ack), .collide(collide),
        .ate(ate), .grow_req(grow_req), .grow_ack(grow_ack), .busy(busy),
        .game_over(game_over), .step_count(step_count), .tick_missed(tick_missed),
        .state_dbg(state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc_now <= cyc_now + 1;

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog expired");
    end

    function automatic int period_of(input int s);
        int p;
        p = DIV_BASE - s * SPEED_STEP;
        return (p < DIV_MIN) ? DIV_MIN : p;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; pause = 1'b0; move_ack = 1'b0;
        grow_ack = 1'b0; collide = 1'b0; ate = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        sb_steps = 16'd0;
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic start_game(output int unsigned t0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        t0 = cyc_now;
        sb_steps = 16'd0;
    endtask

    task automatic wait_move(input int max_cyc, output int unsigned t_rise, output bit ok);
        ok = 1'b0;
        t_rise = 0;
        for (int i = 0; i < max_cyc; i++) begin
            if (move_req === 1'b1) begin
                ok = 1'b1;
                t_rise = cyc_now;
                break;
            end
            @(negedge clk);
        end
        if (!ok) begin
            checks++; errors++;
            $display("FAIL move_req_timeout got=0 want=1 within %0d cycles", max_cyc);
        end
    endtask

    task automatic ack_move(input logic c, input logic a);
        move_ack = 1'b1; collide = c; ate = a;
        if (!c) sb_steps = sb_steps + 16'd1;
        exp_q.push_back(sb_steps);
        @(negedge clk);
        move_ack = 1'b0; collide = 1'b0; ate = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({move_req, grow_req, busy, game_over, tick_missed} !== 5'b0) begin
            errors++; $display("FAIL reset_flags got=%b want=00000",
                               {move_req, grow_req, busy, game_over, tick_missed});
        end
        checks++;
        if (step_count !== 16'd0) begin
            errors++; $display("FAIL reset_steps got=%0d want=0", step_count);
        end
        checks++;
        if (state_dbg !== S_IDLE) begin
            errors++; $display("FAIL reset_state got=%0d want=%0d", state_dbg, S_IDLE);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_first_move();
        int unsigned t0, tr;
        bit ok;
        int dly;
        logic [15:0] exp_s;
        speed = 3'd0; vblank = 1'b1;
        start_game(t0);
        wait_move(30, tr, ok);
        if (ok) begin
            checks++;
            if (tr - t0 !== DIV_BASE + 2) begin
                errors++; $display("FAIL first_latency got=%0d want=%0d", tr - t0, DIV_BASE + 2);
            end
        end
        checks++;
        if (busy !== 1'b1 || state_dbg !== S_MOVE) begin
            errors++; $display("FAIL move_state got=busy%b/st%0d want=busy1/st%0d", busy, state_dbg, S_MOVE);
        end
        dly = $urandom_range(0, 3);
        repeat (dly) @(negedge clk);
        checks++;
        if (move_req !== 1'b1) begin
            errors++; $display("FAIL move_req_hold got=%b want=1", move_req);
        end
        ack_move(1'b0, 1'b0);
        exp_s = exp_q.pop_front();
        checks++;
        if (step_count !== exp_s) begin
            errors++; $display("FAIL first_steps got=%0d want=%0d", step_count, exp_s);
        end
        checks++;
        if (move_req !== 1'b0 || busy !== 1'b0 || state_dbg !== S_RUN) begin
            errors++; $display("FAIL after_ack got=req%b/busy%b/st%0d want=req0/busy0/st%0d",
                               move_req, busy, state_dbg, S_RUN);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (step_count !== sb_steps || state_dbg !== S_RUN) begin
            errors++; $display("FAIL start_in_run got=steps%0d/st%0d want=steps%0d/st%0d",
                               step_count, state_dbg, sb_steps, S_RUN);
        end
    endtask

    task automatic test_speed();
        int unsigned t0, tr, t_prev;
        bit ok;
        int exp_iv[4];
        logic [15:0] exp_s;
        exp_iv[0] = period_of(5) + 2;
        exp_iv[1] = period_of(5);
        exp_iv[2] = period_of(3);
        exp_iv[3] = period_of(1);
        do_reset();
        speed = 3'd5; vblank = 1'b1;
        start_game(t0);
        t_prev = t0;
        for (int k = 0; k < 4; k++) begin
            wait_move(30, tr, ok);
            if (ok) begin
                checks++;
                if (tr - t_prev !== exp_iv[k]) begin
                    errors++; $display("FAIL period_%0d got=%0d want=%0d", k, tr - t_prev, exp_iv[k]);
                end
            end
            t_prev = tr;
            ack_move(1'b0, 1'b0);
            exp_s = exp_q.pop_front();
            checks++;
            if (step_count !== exp_s) begin
                errors++; $display("FAIL speed_steps_%0d got=%0d want=%0d", k, step_count, exp_s);
            end
            if (k == 0) speed = 3'd3;
            if (k == 1) speed = 3'd1;
        end
        checks++;
        if (tick_missed !== 1'b0) begin
            errors++; $display("FAIL speed_no_miss got=%b want=0", tick_missed);
        end
    endtask

    task automatic test_grow_over();
        int unsigned t0, tr;
        bit ok, held;
        int hold;
        logic [15:0] exp_s;
        do_reset();
        speed = 3'd0; vblank = 1'b1;
        start_game(t0);
        wait_move(30, tr, ok);
        ack_move(1'b0, 1'b1);
        exp_s = exp_q.pop_front();
        checks++;
        if (step_count !== exp_s) begin
            errors++; $display("FAIL grow_steps got=%0d want=%0d", step_count, exp_s);
        end
        checks++;
        if (move_req !== 1'b0 || grow_req !== 1'b1 || busy !== 1'b1 || state_dbg !== S_GROW) begin
            errors++; $display("FAIL grow_entry got=mreq%b/greq%b/busy%b/st%0d want=0/1/1/%0d",
                               move_req, grow_req, busy, state_dbg, S_GROW);
        end
        hold = $urandom_range(2, 5);
        held = 1'b1;
        move_ack = 1'b1; collide = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            move_ack = 1'b0; collide = 1'b0;
            if (grow_req !== 1'b1 || state_dbg !== S_GROW) held = 1'b0;
        end
        checks++;
        if (held !== 1'b1) begin
            errors++; $display("FAIL grow_hold got=0 want=1");
        end
        grow_ack = 1'b1;
        @(negedge clk);
        grow_ack = 1'b0;
        checks++;
        if (grow_req !== 1'b0 || busy !== 1'b0 || state_dbg !== S_RUN) begin
            errors++; $display("FAIL grow_done got=greq%b/busy%b/st%0d want=0/0/%0d",
                               grow_req, busy, state_dbg, S_RUN);
        end
        wait_move(30, tr, ok);
        ack_move(1'b1, 1'b1);
        exp_s = exp_q.pop_front();
        checks++;
        if (step_count !== exp_s) begin
            errors++; $display("FAIL collide_steps got=%0d want=%0d", step_count, exp_s);
        end
        checks++;
        if (game_over !== 1'b1 || grow_req !== 1'b0 || busy !== 1'b0 || state_dbg !== S_OVER) begin
            errors++; $display("FAIL over_entry got=go%b/greq%b/busy%b/st%0d want=1/0/0/%0d",
                               game_over, grow_req, busy, state_dbg, S_OVER);
        end
        held = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (move_req !== 1'b0 || state_dbg !== S_OVER || step_count !== sb_steps) held = 1'b0;
        end
        checks++;
        if (held !== 1'b1) begin
            errors++; $display("FAIL over_frozen got=0 want=1");
        end
        start_game(t0);
        checks++;
        if (step_count !== 16'd0 || game_over !== 1'b0 || state_dbg !== S_RUN) begin
            errors++; $display("FAIL restart got=steps%0d/go%b/st%0d want=0/0/%0d",
                               step_count, game_over, state_dbg, S_RUN);
        end
        wait_move(30, tr, ok);
        if (ok) begin
            checks++;
            if (tr - t0 !== DIV_BASE + 2) begin
                errors++; $display("FAIL restart_latency got=%0d want=%0d", tr - t0, DIV_BASE + 2);
            end
        end
        ack_move(1'b0, 1'b0);
        exp_s = exp_q.pop_front();
        checks++;
        if (step_count !== exp_s) begin
            errors++; $display("FAIL restart_steps got=%0d want=%0d", step_count, exp_s);
        end
    endtask

    task automatic test_vblank_wait();
        int unsigned t0, tr;
        bit ok, quiet;
        int lat;
        logic [15:0] exp_s;
        do_reset();
        speed = 3'd0; vblank = 1'b0;
        start_game(t0);
        lat = -1;
        for (int i = 0; i < 30; i++) begin
            if (busy === 1'b1) begin
                lat = int'(cyc_now - t0);
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (lat !== DIV_BASE + 1) begin
            errors++; $display("FAIL busy_latency got=%0d want=%0d", lat, DIV_BASE + 1);
        end
        quiet = 1'b1;
        for (int i = 1; i <= 25; i++) begin
            @(negedge clk);
            if (move_req !== 1'b0 || busy !== 1'b1) quiet = 1'b0;
            if (i == DIV_BASE - 2) begin
                checks++;
                if (tick_missed !== 1'b0) begin
                    errors++; $display("FAIL miss_early got=%b want=0", tick_missed);
                end
            end
        end
        checks++;
        if (quiet !== 1'b1) begin
            errors++; $display("FAIL vb_wait_quiet got=0 want=1");
        end
        checks++;
        if (tick_missed !== 1'b1) begin
            errors++; $display("FAIL miss_set got=%b want=1", tick_missed);
        end
        vblank = 1'b1;
        wait_move(3, tr, ok);
        ack_move(1'b0, 1'b0);
        exp_s = exp_q.pop_front();
        checks++;
        if (step_count !== exp_s) begin
            errors++; $display("FAIL vb_steps got=%0d want=%0d", step_count, exp_s);
        end
        quiet = 1'b1;
        repeat (3) begin
            if (move_req !== 1'b0) quiet = 1'b0;
            @(negedge clk);
        end
        checks++;
        if (quiet !== 1'b1 || tick_missed !== 1'b1) begin
            errors++; $display("FAIL vb_single got=quiet%b/miss%b want=1/1", quiet, tick_missed);
        end
    endtask

    task automatic test_pause();
        int unsigned t0, tr;
        bit ok, quiet;
        logic [15:0] exp_s;
        do_reset();
        speed = 3'd0; vblank = 1'b1;
        start_game(t0);
        repeat (5) @(negedge clk);
        pause = 1'b1;
        quiet = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (move_req !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
        end
        pause = 1'b0;
        checks++;
        if (quiet !== 1'b1) begin
            errors++; $display("FAIL pause_quiet got=0 want=1");
        end
        wait_move(30, tr, ok);
        if (ok) begin
            checks++;
            if (tr - t0 !== DIV_BASE + 2 + 30) begin
                errors++; $display("FAIL pause_latency got=%0d want=%0d", tr - t0, DIV_BASE + 32);
            end
        end
        pause = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (move_req !== 1'b1 || state_dbg !== S_MOVE) begin
            errors++; $display("FAIL pause_in_move got=req%b/st%0d want=1/%0d", move_req, state_dbg, S_MOVE);
        end
        ack_move(1'b0, 1'b0);
        exp_s = exp_q.pop_front();
        checks++;
        if (step_count !== exp_s || state_dbg !== S_RUN || move_req !== 1'b0) begin
            errors++; $display("FAIL pause_ack got=steps%0d/st%0d/req%b want=%0d/%0d/0",
                               step_count, state_dbg, move_req, exp_s, S_RUN);
        end
        pause = 1'b0;
    endtask

    task automatic test_reset_abort();
        int unsigned t0, tr;
        bit ok;
        do_reset();
        speed = 3'd0; vblank = 1'b1;
        start_game(t0);
        @(negedge clk);
        move_ack = 1'b1; collide = 1'b1;
        @(negedge clk);
        move_ack = 1'b0; collide = 1'b0;
        checks++;
        if (state_dbg !== S_RUN || game_over !== 1'b0) begin
            errors++; $display("FAIL stray_ack got=st%0d/go%b want=%0d/0", state_dbg, game_over, S_RUN);
        end
        wait_move(30, tr, ok);
        rst_n = 1'b0;
        #1;
        checks++;
        if ({move_req, grow_req, busy, game_over, tick_missed} !== 5'b0 ||
            step_count !== 16'd0 || state_dbg !== S_IDLE) begin
            errors++; $display("FAIL async_abort got=%b/steps%0d/st%0d want=00000/0/%0d",
                               {move_req, grow_req, busy, game_over, tick_missed},
                               step_count, state_dbg, S_IDLE);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb_steps = 16'd0;
        exp_q.delete();
        @(negedge clk);
        move_ack = 1'b1;
        @(negedge clk);
        move_ack = 1'b0;
        @(negedge clk);
        checks++;
        if (state_dbg !== S_IDLE || move_req !== 1'b0 || step_count !== sb_steps) begin
            errors++; $display("FAIL late_ack got=st%0d/req%b/steps%0d want=%0d/0/%0d",
                               state_dbg, move_req, step_count, S_IDLE, sb_steps);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_first_move();
        test_speed();
        test_grow_over();
        test_vblank_wait();
        test_pause();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/snake_step_scheduler.md
SNAKE_STEP_SCHEDULER -- requirements
Module: snake_step_scheduler

Interface
REQ-001 SHALL have parameter DIV_BASE, default 4000000: tick period in clk cycles at speed 0.
REQ-002 SHALL have parameter SPEED_STEP, default 400000: period reduction per speed level.
REQ-003 SHALL have parameter DIV_MIN, default 1000000: period floor.
REQ-004 SHALL have parameter CW, default 22: divider counter width.
REQ-005 SHALL have port clk  in  1: single system clock; all logic on its rising edge.
REQ-006 SHALL have port rst_n  in  1: asynchronous, active-low reset.
REQ-007 SHALL have port start  in  1: one-cycle pulse that starts or restarts a game.
REQ-008 SHALL have port pause  in  1: level; freezes tick generation.
REQ-009 SHALL have port speed  in  3: speed level 0..7.
REQ-010 SHALL have port vblank  in  1: level; high during VGA vertical blank.
REQ-011 SHALL have port move_req  out  1: request to the game datapath to advance the snake one cell.
REQ-012 SHALL have port move_ack  in  1: one-cycle completion of a move.
REQ-013 SHALL have port collide  in  1: sampled only in the move_ack cycle; head hit a wall or the body.
REQ-014 SHALL have port ate  in  1: sampled only in the move_ack cycle; head reached food.
REQ-015 SHALL have port grow_req  out  1: request to lengthen the snake and respawn food.
REQ-016 SHALL have port grow_ack  in  1: one-cycle completion of a grow.
REQ-017 SHALL have port busy  out  1: high in WAIT_VB, MOVE or GROW.
REQ-018 SHALL have port game_over  out  1: high in OVER.
REQ-019 SHALL have port step_count  out  16: count of completed non-colliding moves.
REQ-020 SHALL have port tick_missed  out  1: sticky overrun flag.

Function
REQ-021 SHALL use period P = max(DIV_BASE - speed*SPEED_STEP, DIV_MIN), computed at CW bits without underflow.
REQ-022 SHALL latch speed only when the counter equals 0, so a change takes effect at the next period boundary.
REQ-023 SHALL increment the divider each cycle in RUN, WAIT_VB, MOVE and GROW while pause=0; pause=1 holds its value.
REQ-024 SHALL, when the counter equals P-1, reset it to 0 and set tick_pending on the next edge.
REQ-025 SHALL set tick_missed and leave tick_pending at 1 if a tick occurs while tick_pending is already 1; tick_missed clears only on start or reset.
REQ-026 SHALL implement these states: IDLE, RUN, WAIT_VB, MOVE, GROW, OVER.
REQ-027 SHALL move IDLE->RUN on start, clearing the counter, tick_pending, tick_missed and step_count.
REQ-028 SHALL move RUN->WAIT_VB when tick_pending=1 and pause=0.
REQ-029 SHALL move WAIT_VB->MOVE in the first cycle with vblank=1, clearing tick_pending on the same edge; if vblank is already high, WAIT_VB lasts exactly 1 cycle.
REQ-030 SHALL drive move_req high from MOVE entry through the move_ack cycle inclusive, and low the cycle after.
REQ-031 SHALL, in the move_ack cycle, go to OVER if collide=1 (step_count unchanged, ate ignored); otherwise increment step_count (0xFFFF wraps to 0) and go to GROW if ate=1, else to RUN.
REQ-032 SHALL drive grow_req high from GROW entry through the grow_ack cycle, then go to RUN.
REQ-033 SHALL ignore move_ack outside MOVE and grow_ack outside GROW.
REQ-034 SHALL not abort an in-flight handshake on pause; pause only blocks RUN->WAIT_VB and divider counting.
REQ-035 SHALL halt the divider in OVER and hold step_count.
REQ-036 SHALL move OVER->RUN on start with the clears of REQ-027.
REQ-037 SHALL ignore start in RUN, WAIT_VB, MOVE and GROW.
REQ-038 SHALL drive every output from registers.

Reset
REQ-039 SHALL, while rst_n=0, asynchronously force: state IDLE, counter 0, tick_pending 0, latched speed 0, move_req 0, grow_req 0, busy 0, game_over 0, step_count 0, tick_missed 0.
REQ-040 SHALL treat rst_n asserted mid-handshake as an abort: move_req and grow_req drop immediately, and no ack is awaited after release.

Verification (DIV_BASE=10, SPEED_STEP=2, DIV_MIN=4, CW=5)
REQ-041 SHALL cover: speed=0, vblank=1, start -> move_req rises 12 cycles after start (10 to tick, +1 pending, +1 WAIT_VB); ack with collide=0, ate=0 -> step_count=1, state RUN.
REQ-042 SHALL cover: speed=5 -> period 4 (floor); speed changed 3->1 mid-period -> current period stays 4, next period is 8.
REQ-043 SHALL cover: ack with ate=1 -> grow_req high next cycle, held until grow_ack, then RUN; ack with collide=1 and ate=1 -> game_over=1, no grow_req, step_count unchanged, divider frozen; start -> RUN with step_count=0.
REQ-044 SHALL cover: vblank=0 held for 25 cycles after a tick -> busy=1, no move_req, tick_missed=1 after the second tick; vblank=1 -> single move_req.
REQ-045 SHALL cover: pause=1 for 30 cycles in RUN -> no tick, counter held; pause during MOVE -> handshake completes normally.
REQ-046 SHALL cover: rst_n low for 1 cycle while move_req=1 -> all outputs at reset values immediately; later move_ack pulse ignored.
